mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter ILL_HALT, default 0: 1 = an undefined opcode/funct parks the FSM in HALT until reset; 0 = the instruction retires as a NOP.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port Op, input, 6 bits: instruction opcode from the IR.
REQ-005 The block SHALL have port Funct, input, 6 bits: instruction funct field from the IR.
REQ-006 The block SHALL have port Zero, input, 1 bit: the ALU zero flag, sampled in BRANCH.
REQ-007 The block SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, IorD, ALUSrcA and EXTOp, 1 bit each: datapath strobes and selects.
REQ-008 The block SHALL have outputs ALUSrcB, RegDst, WDSel and PCSource, 2 bits each: mux selects.
REQ-009 The block SHALL have output ALUOp, 3 bits: ALU function, using the shared ALU_* defines.
REQ-010 The block SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-011 Outputs SHALL be Moore, decoded from state plus the latched instruction class only.
- Exception: PCWrite in BRANCH also depends on Zero.
REQ-012 The FSM SHALL implement these states and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JUMP=10, HALT=15
REQ-013 FETCH SHALL drive IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01 (+4), ALUOp=ALU_ADD, PCSource=00, PCWrite=1; next state DECODE.
REQ-014 DECODE SHALL latch the instruction class into a register and compute the branch target: ALUSrcA=0, ALUSrcB=11, EXTOp=1, ALUOp=ALU_ADD.
REQ-015 DECODE SHALL transition as follows:
- lw/sw -> MEMADR
- R-type -> EXEC_R
- addi/ori/lui/slti -> EXEC_I
- beq/bne -> BRANCH
- j/jal -> JUMP
- undefined -> HALT if ILL_HALT=1, else FETCH
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ALU_ADD; next state MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD SHALL drive IorD=1; next state MEMWB. MEMWB SHALL drive RegWrite=1, RegDst=00 (rt), WDSel=01 (mem); next state FETCH.
REQ-018 MEMWR SHALL drive IorD=1 and MemWrite=1 for exactly one cycle; next state FETCH.
REQ-019 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, with ALUOp from Funct:
- 100001 -> ADD
- 100011 -> SUB
- 100100 -> AND
- 100101 -> OR
- 100111 -> NOR
- 101010 -> SLT
- 101011 -> SLTU
- other -> undefined (REQ-015 rule applied, no ALUWB)
REQ-020 EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10 with:
- addi: EXTOp=1, ALU_ADD
- slti: EXTOp=1, ALU_SLT
- ori: EXTOp=0, ALU_OR
- lui: ALU_LUI
REQ-021 ALUWB SHALL drive RegWrite=1 and WDSel=00 (ALU), with RegDst=01 (rd) after EXEC_R and 00 after EXEC_I; next state FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=ALU_SUB, PCSource=01, with PCWrite = Zero for beq and ~Zero for bne; next state FETCH.
REQ-023 JUMP SHALL drive PCSource=10 and PCWrite=1; for jal it SHALL also drive RegWrite=1, RegDst=10 ($31), WDSel=10 (PC); next state FETCH.
REQ-024 In all states, any strobe not named above SHALL be 0 and any select not named above SHALL be 0.
REQ-025 HALT SHALL hold all strobes at 0 and leave only on reset.
REQ-026 Cycles per instruction SHALL be:
- lw 5; sw 4; R-type and ALU-immediate 4; branch 3; j/jal 3
REQ-027 Exactly one RegWrite or MemWrite pulse SHALL occur per retired instruction, except branch/j, which have none.

Reset
REQ-028 With rstn=0 at a rising edge, state SHALL become FETCH and the latched class SHALL be cleared, regardless of the current state (including mid-instruction and HALT).
REQ-029 While state=FETCH after reset, all write strobes SHALL be 0 during the reset cycle itself; PCWrite and IRWrite SHALL first assert in the cycle after rstn returns to 1.

Verification
REQ-030 The bench SHALL cover lw (Op=100011): state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with WDSel=01.
REQ-031 The bench SHALL cover subu (Op=0, Funct=100011): ALUOp=ALU_SUB in state 6; RegWrite=1 and RegDst=01 in state 8; 4 cycles total.
REQ-032 The bench SHALL cover beq: with Zero=1, PCWrite=1 and PCSource=01 in state 9; with Zero=0, PCWrite=0. The bench SHALL also cover bne with the inverse.
REQ-033 The bench SHALL cover jal (Op=000011): state 10 asserts PCWrite=1, RegWrite=1, RegDst=10, WDSel=10; next state FETCH.
REQ-034 The bench SHALL cover Op=111111: with ILL_HALT=1, state=15 persists for 20 cycles with no strobes; with ILL_HALT=0, FETCH follows DECODE.
REQ-035 The bench SHALL cover reset mid-instruction: rstn=0 in state 5 -> MemWrite=0 after the edge and state=0; fetch resumes one cycle after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM. Datapath strobes are Moore outputs of the
// current state and the instruction class latched in DECODE.
module mc_ctrl #(
   parameter bit ILL_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       EXTOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic [3:0] state
);

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_NOR  = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;
   localparam logic [2:0] ALU_SLTU = 3'd6;
   localparam logic [2:0] ALU_LUI  = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_EXEC_I = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_HALT   = 4'd15
   } state_e;

   typedef enum logic [3:0] {
      C_NONE, C_LW, C_SW, C_RTYPE, C_ADDI, C_SLTI, C_ORI, C_LUI,
      C_BEQ, C_BNE, C_J, C_JAL, C_ILL
   } cls_e;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       iord;
      logic       alu_src_a;
      logic       ext_op;
      logic [1:0] alu_src_b;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
   } ctrl_t;

   state_e     state_q, state_d;
   cls_e       cls_q, cls_d, dec_cls;
   logic [2:0] r_alu_q, r_alu_d, dec_r_alu;
   logic       run_q;
   ctrl_t      ctrl_q, ctrl_d;
   logic       br_take;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      dec_cls   = C_ILL;
      dec_r_alu = ALU_ADD;
      case (Op)
         OP_RTYPE: begin
            dec_cls = C_RTYPE;
            case (Funct)
               6'b100001: dec_r_alu = ALU_ADD;
               6'b100011: dec_r_alu = ALU_SUB;
               6'b100100: dec_r_alu = ALU_AND;
               6'b100101: dec_r_alu = ALU_OR;
               6'b100111: dec_r_alu = ALU_NOR;
               6'b101010: dec_r_alu = ALU_SLT;
               6'b101011: dec_r_alu = ALU_SLTU;
               default:   dec_cls   = C_ILL;
            endcase
         end
         OP_LW:   dec_cls = C_LW;
         OP_SW:   dec_cls = C_SW;
         OP_ADDI: dec_cls = C_ADDI;
         OP_SLTI: dec_cls = C_SLTI;
         OP_ORI:  dec_cls = C_ORI;
         OP_LUI:  dec_cls = C_LUI;
         OP_BEQ:  dec_cls = C_BEQ;
         OP_BNE:  dec_cls = C_BNE;
         OP_J:    dec_cls = C_J;
         OP_JAL:  dec_cls = C_JAL;
         default: dec_cls = C_ILL;
      endcase
   end

   // The first clock after reset release only arms the outputs; FETCH is held one
   // extra cycle so the fetch strobes are seen with rstn already high.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      r_alu_d = r_alu_q;
      if (!run_q) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
               cls_d   = dec_cls;
               r_alu_d = dec_r_alu;
               case (dec_cls)
                  C_LW, C_SW:                    state_d = S_MEMADR;
                  C_RTYPE:                       state_d = S_EXEC_R;
                  C_ADDI, C_SLTI, C_ORI, C_LUI:  state_d = S_EXEC_I;
                  C_BEQ, C_BNE:                  state_d = S_BRANCH;
                  C_J, C_JAL:                    state_d = S_JUMP;
                  default:                       state_d = ILL_HALT ? S_HALT : S_FETCH;
               endcase
            end
            S_MEMADR: state_d = (cls_q == C_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   // Outputs are decoded from the state being entered so they register alongside it.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_FETCH: begin
            ctrl_d.ir_write  = 1'b1;
            ctrl_d.pc_write  = 1'b1;
            ctrl_d.alu_src_b = 2'b01;
            ctrl_d.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            ctrl_d.alu_src_b = 2'b11;
            ctrl_d.ext_op    = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            ctrl_d.ext_op    = 1'b1;
            ctrl_d.alu_op    = ALU_ADD;
         end
         S_MEMRD: ctrl_d.iord = 1'b1;
         S_MEMWB: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.wd_sel    = 2'b01;
         end
         S_MEMWR: begin
            ctrl_d.iord      = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         S_EXEC_R: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = r_alu_d;
         end
         S_EXEC_I: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            case (cls_d)
               C_ADDI: begin ctrl_d.ext_op = 1'b1; ctrl_d.alu_op = ALU_ADD; end
               C_SLTI: begin ctrl_d.ext_op = 1'b1; ctrl_d.alu_op = ALU_SLT; end
               C_ORI:  ctrl_d.alu_op = ALU_OR;
               C_LUI:  ctrl_d.alu_op = ALU_LUI;
               default: ;
            endcase
         end
         S_ALUWB: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.reg_dst   = (cls_d == C_RTYPE) ? 2'b01 : 2'b00;
         end
         S_BRANCH: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = ALU_SUB;
            ctrl_d.pc_source = 2'b01;
         end
         S_JUMP: begin
            ctrl_d.pc_source = 2'b10;
            ctrl_d.pc_write  = 1'b1;
            if (cls_d == C_JAL) begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.reg_dst   = 2'b10;
               ctrl_d.wd_sel    = 2'b10;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (!rstn) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
         r_alu_q <= ALU_ADD;
         run_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         r_alu_q <= r_alu_d;
         run_q   <= 1'b1;
         ctrl_q  <= ctrl_d;
      end
   end

   // The ALU zero flag is only valid during BRANCH, so that one strobe stays combinational.
   assign br_take = (state_q == S_BRANCH) &&
                    ((cls_q == C_BEQ) ? Zero : ((cls_q == C_BNE) && !Zero));

   assign PCWrite  = ctrl_q.pc_write | br_take;
   assign IRWrite  = ctrl_q.ir_write;
   assign RegWrite = ctrl_q.reg_write;
   assign MemWrite = ctrl_q.mem_write;
   assign IorD     = ctrl_q.iord;
   assign ALUSrcA  = ctrl_q.alu_src_a;
   assign EXTOp    = ctrl_q.ext_op;
   assign ALUSrcB  = ctrl_q.alu_src_b;
   assign RegDst   = ctrl_q.reg_dst;
   assign WDSel    = ctrl_q.wd_sel;
   assign PCSource = ctrl_q.pc_source;
   assign ALUOp    = ctrl_q.alu_op;
   assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected output vectors are queued per
// instruction and compared against the DUT each cycle.
module tb_mc_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ILL  = 6'b111111;

   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3;
   localparam logic [2:0] A_NOR = 3'd4, A_SLT = 3'd5, A_SLTU = 3'd6, A_LUI = 3'd7;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rw, mw, iord, srca, ext;
      logic [1:0] srcb, rdst, wds, pcs;
      logic [2:0] aluop;
   } obs_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [5:0] Op = '0, Funct = '0;
   logic       Zero = 1'b0;

   logic       pcw, irw, rw, mw, iord, srca, ext;
   logic [1:0] srcb, rdst, wds, pcs;
   logic [2:0] aluop;
   logic [3:0] st;
   logic       pcw_h, irw_h, rw_h, mw_h, iord_h, srca_h, ext_h;
   logic [1:0] srcb_h, rdst_h, wds_h, pcs_h;
   logic [2:0] aluop_h;
   logic [3:0] st_h;

   obs_t obs, obs_h;
   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.ILL_HALT(1'b0)) dut (
      .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(pcw), .IRWrite(irw), .RegWrite(rw), .MemWrite(mw), .IorD(iord),
      .ALUSrcA(srca), .EXTOp(ext), .ALUSrcB(srcb), .RegDst(rdst), .WDSel(wds),
      .PCSource(pcs), .ALUOp(aluop), .state(st)
   );

   mc_ctrl #(.ILL_HALT(1'b1)) dut_h (
      .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(pcw_h), .IRWrite(irw_h), .RegWrite(rw_h), .MemWrite(mw_h), .IorD(iord_h),
      .ALUSrcA(srca_h), .EXTOp(ext_h), .ALUSrcB(srcb_h), .RegDst(rdst_h), .WDSel(wds_h),
      .PCSource(pcs_h), .ALUOp(aluop_h), .state(st_h)
   );

   assign obs   = {st, pcw, irw, rw, mw, iord, srca, ext, srcb, rdst, wds, pcs, aluop};
   assign obs_h = {st_h, pcw_h, irw_h, rw_h, mw_h, iord_h, srca_h, ext_h,
                   srcb_h, rdst_h, wds_h, pcs_h, aluop_h};

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100001: return A_ADD;
         6'b100011: return A_SUB;
         6'b100100: return A_AND;
         6'b100101: return A_OR;
         6'b100111: return A_NOR;
         6'b101010: return A_SLT;
         default:   return A_SLTU;
      endcase
   endfunction

   // Reference outputs for one cycle spent in state s while executing (op, fn, z).
   function automatic obs_t exp_for(input logic [3:0] s, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z);
      obs_t e;
      e = '0;
      e.st = s;
      case (s)
         4'd0: begin e.pcw = 1; e.irw = 1; e.srcb = 2'b01; e.aluop = A_ADD; end
         4'd1: begin e.srcb = 2'b11; e.ext = 1; e.aluop = A_ADD; end
         4'd2: begin e.srca = 1; e.srcb = 2'b10; e.ext = 1; e.aluop = A_ADD; end
         4'd3: e.iord = 1;
         4'd4: begin e.rw = 1; e.wds = 2'b01; e.rdst = 2'b00; end
         4'd5: begin e.iord = 1; e.mw = 1; end
         4'd6: begin e.srca = 1; e.srcb = 2'b00; e.aluop = r_alu(fn); end
         4'd7: begin
            e.srca = 1; e.srcb = 2'b10;
            if (op == OP_ADDI)      begin e.ext = 1; e.aluop = A_ADD; end
            else if (op == OP_SLTI) begin e.ext = 1; e.aluop = A_SLT; end
            else if (op == OP_ORI)  e.aluop = A_OR;
            else                    e.aluop = A_LUI;
         end
         4'd8: begin e.rw = 1; e.wds = 2'b00; e.rdst = (op == OP_R) ? 2'b01 : 2'b00; end
         4'd9: begin
            e.srca = 1; e.aluop = A_SUB; e.pcs = 2'b01;
            e.pcw = (op == OP_BEQ) ? z : ~z;
         end
         4'd10: begin
            e.pcs = 2'b10; e.pcw = 1;
            if (op == OP_JAL) begin e.rw = 1; e.rdst = 2'b10; e.wds = 2'b10; end
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic int exp_writes(input logic [5:0] op);
      case (op)
         OP_BEQ, OP_BNE, OP_J, OP_ILL: return 0;
         default: return 1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      logic [3:0] seq[$];
      seq = {4'd0, 4'd1};
      case (op)
         OP_LW:  begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
         OP_SW:  begin seq.push_back(4'd2); seq.push_back(4'd5); end
         OP_R:   begin seq.push_back(4'd6); seq.push_back(4'd8); end
         OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: begin seq.push_back(4'd7); seq.push_back(4'd8); end
         OP_BEQ, OP_BNE: seq.push_back(4'd9);
         OP_J, OP_JAL:   seq.push_back(4'd10);
         default: ;
      endcase
      foreach (seq[i]) exp_q.push_back(exp_for(seq[i], op, fn, z));
   endtask

   // Issues one instruction from a FETCH cycle and checks every cycle until the next FETCH.
   task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic z);
      obs_t e;
      int   writes = 0;
      int   cyc = 0;
      Op = op; Funct = fn; Zero = z;
      push_instr(op, fn, z);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, obs, e);
         else n_pass++;
         writes += int'(rw) + int'(mw);
         step();
         cyc++;
      end
      n_checks++;
      if (writes !== exp_writes(op))
         $display("FAIL %s_writes: got %0d expected %0d", name, writes, exp_writes(op));
      else n_pass++;
      n_checks++;
      if (st !== 4'd0) $display("FAIL %s_cpi: state got %0d expected 0", name, st);
      else n_pass++;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step(); step(); step();
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h00 || {st_h, pcw_h, irw_h, rw_h, mw_h} !== 8'h00)
         $display("FAIL reset_hold: got %h/%h expected 00/00",
                  {st, pcw, irw, rw, mw}, {st_h, pcw_h, irw_h, rw_h, mw_h});
      else n_pass++;
      rstn = 1'b1;
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h00)
         $display("FAIL reset_release_cycle: got %h expected 00", {st, pcw, irw, rw, mw});
      else n_pass++;
      step();
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h0C)
         $display("FAIL reset_first_fetch: got %h expected 0c", {st, pcw, irw, rw, mw});
      else n_pass++;
   endtask

   task automatic test_mem();
      run("lw", OP_LW, 6'd0, 1'b0);
      run("sw", OP_SW, 6'd0, 1'b0);
   endtask

   task automatic test_rtype();
      logic [5:0] fns[7];
      fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011};
      foreach (fns[i]) run($sformatf("rtype_%b", fns[i]), OP_R, fns[i], 1'b0);
   endtask

   task automatic test_imm();
      run("addi", OP_ADDI, 6'd0, 1'b0);
      run("slti", OP_SLTI, 6'd0, 1'b0);
      run("ori",  OP_ORI,  6'd0, 1'b0);
      run("lui",  OP_LUI,  6'd0, 1'b0);
   endtask

   task automatic test_branch();
      run("beq_taken",    OP_BEQ, 6'd0, 1'b1);
      run("beq_nottaken", OP_BEQ, 6'd0, 1'b0);
      run("bne_taken",    OP_BNE, 6'd0, 1'b0);
      run("bne_nottaken", OP_BNE, 6'd0, 1'b1);
   endtask

   task automatic test_jump();
      run("j",   OP_J,   6'd0, 1'b0);
      run("jal", OP_JAL, 6'd0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[11];
      logic [5:0] op;
      ops = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL};
      for (int i = 0; i < 16; i++) begin
         op = ops[$urandom_range(0, 10)];
         run($sformatf("b2b_%0d", i), op, 6'b100000 | 6'($urandom_range(0, 1) ? 6'b000011 : 6'b000101),
             1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_illegal();
      run("ill_nop", OP_ILL, 6'd0, 1'b0);
      for (int i = 0; i < 20; i++) exp_q.push_back(exp_for(4'd15, OP_ILL, 6'd0, 1'b0));
      while (exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_h !== e) $display("FAIL halt_hold: got %h expected %h", obs_h, e);
         else n_pass++;
         step();
      end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      n_checks++;
      if (st_h !== 4'd0) $display("FAIL halt_reset: state got %0d expected 0", st_h);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      Op = OP_SW; Funct = '0; Zero = 1'b0;
      step(); step(); step();
      n_checks++;
      if ({st, mw} !== 5'b0101_1) $display("FAIL mid_in_memwr: got %b expected 01011", {st, mw});
      else n_pass++;
      rstn = 1'b0;
      step();
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h00)
         $display("FAIL mid_reset: got %h expected 00", {st, pcw, irw, rw, mw});
      else n_pass++;
      rstn = 1'b1;
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h00)
         $display("FAIL mid_release_cycle: got %h expected 00", {st, pcw, irw, rw, mw});
      else n_pass++;
      step();
      n_checks++;
      if ({st, pcw, irw, rw, mw} !== 8'h0C)
         $display("FAIL mid_fetch_resume: got %h expected 0c", {st, pcw, irw, rw, mw});
      else n_pass++;
      run("lw_after_reset", OP_LW, 6'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_mem();
      test_rtype();
      test_imm();
      test_branch();
      test_jump();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
